// File: rtl/atm_pkg.sv
// Shared op/status encodings for the ATM card traffic between terminal and bank.
package atm_pkg;
   localparam int STATUS_W = 3;

   typedef enum logic [1:0] {
      OP_VERIFY    = 2'd0,
      OP_READ_BAL  = 2'd1,
      OP_UPDATE    = 2'd2,
      OP_PROVISION = 2'd3
   } op_e;

   typedef enum logic [STATUS_W-1:0] {
      ST_OK         = 3'd0,
      ST_BAD_PSW    = 3'd1,
      ST_LOCKED     = 3'd2,
      ST_NO_ACCOUNT = 3'd3,
      ST_NO_SESSION = 3'd4
   } status_e;
endpackage

// File: rtl/account_store.sv
// Per-card account register array: one registered read port, one write port.
module account_store #(
   parameter int CARD_W = 6,
   parameter int PSW_W  = 16,
   parameter int BAL_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [CARD_W-1:0] rd_addr,
   output logic              rd_prov,
   output logic              rd_locked,
   output logic [1:0]        rd_fail,
   output logic [PSW_W-1:0]  rd_psw,
   output logic [BAL_W-1:0]  rd_bal,
   input  logic              wr_en,
   input  logic [CARD_W-1:0] wr_addr,
   input  logic              wr_prov,
   input  logic              wr_locked,
   input  logic [1:0]        wr_fail,
   input  logic [PSW_W-1:0]  wr_psw,
   input  logic [BAL_W-1:0]  wr_bal
);
   typedef struct packed {
      logic             prov;
      logic             locked;
      logic [1:0]       fail;
      logic [PSW_W-1:0] psw;
      logic [BAL_W-1:0] bal;
   } entry_t;

   entry_t mem [2**CARD_W];
   entry_t rd_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2**CARD_W; i++) mem[i] <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= '{wr_prov, wr_locked, wr_fail, wr_psw, wr_bal};
         if (rd_en) rd_q <= mem[rd_addr];
      end
   end

   assign rd_prov   = rd_q.prov;
   assign rd_locked = rd_q.locked;
   assign rd_fail   = rd_q.fail;
   assign rd_psw    = rd_q.psw;
   assign rd_bal    = rd_q.bal;
endmodule

// File: rtl/bank_account_server.sv
// Bank-side responder: authenticates cards, serves balances, commits write-backs.
module bank_account_server
   import atm_pkg::*;
#(
   parameter int card_width     = 6,
   parameter int password_width = 16,
   parameter int balance_width  = 20,
   parameter int max_tries      = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [card_width-1:0]     req_card,
   input  logic [password_width-1:0] req_password,
   input  logic [balance_width-1:0]  req_balance,
   input  logic                      session_close,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [STATUS_W-1:0]       resp_status,
   output logic [balance_width-1:0]  resp_balance,
   output logic                      session_open
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_e;
   localparam logic [2:0] MAX_T = 3'(max_tries);

   state_e                    state;
   op_e                       op_q;
   logic [card_width-1:0]     card_q, session_card;
   logic [password_width-1:0] psw_q;
   logic [balance_width-1:0]  bal_q;

   logic                      rd_prov, rd_locked;
   logic [1:0]                rd_fail;
   logic [password_width-1:0] rd_psw;
   logic [balance_width-1:0]  rd_bal;

   logic                      wr_en, wr_prov, wr_locked;
   logic [1:0]                wr_fail;
   logic [password_width-1:0] wr_psw;
   logic [balance_width-1:0]  wr_bal, rbal_nxt;
   logic [2:0]                fail_inc;
   logic                      same_card, sess_nxt;
   logic [card_width-1:0]     sess_card_nxt;
   status_e                   st_nxt;

   account_store #(.CARD_W(card_width), .PSW_W(password_width), .BAL_W(balance_width)) u_store (
      .clk(clk), .rst(rst),
      .rd_en(state == S_READ), .rd_addr(card_q),
      .rd_prov(rd_prov), .rd_locked(rd_locked), .rd_fail(rd_fail), .rd_psw(rd_psw), .rd_bal(rd_bal),
      .wr_en(wr_en && state == S_EXEC), .wr_addr(card_q),
      .wr_prov(wr_prov), .wr_locked(wr_locked), .wr_fail(wr_fail), .wr_psw(wr_psw), .wr_bal(wr_bal)
   );

   // EXEC decision: sees session state as registered before this cycle.
   always_comb begin
      wr_en         = 1'b0;
      wr_prov       = rd_prov;
      wr_locked     = rd_locked;
      wr_fail       = rd_fail;
      wr_psw        = rd_psw;
      wr_bal        = rd_bal;
      st_nxt        = ST_OK;
      rbal_nxt      = '0;
      sess_nxt      = session_open;
      sess_card_nxt = session_card;
      same_card     = session_open && (session_card == card_q);
      fail_inc      = {1'b0, rd_fail} + 3'd1;
      if (op_q == OP_VERIFY) sess_nxt = 1'b0;
      if (op_q == OP_PROVISION) begin
         wr_en     = 1'b1;
         wr_prov   = 1'b1;
         wr_locked = 1'b0;
         wr_fail   = 2'd0;
         wr_psw    = psw_q;
         wr_bal    = bal_q;
         rbal_nxt  = bal_q;
         if (same_card) sess_nxt = 1'b0;
      end else if (!rd_prov) begin
         st_nxt = ST_NO_ACCOUNT;
      end else if (rd_locked) begin
         st_nxt = ST_LOCKED;
      end else begin
         case (op_q)
            OP_VERIFY: begin
               wr_en = 1'b1;
               if (psw_q == rd_psw) begin
                  wr_fail       = 2'd0;
                  sess_nxt      = 1'b1;
                  sess_card_nxt = card_q;
                  rbal_nxt      = rd_bal;
               end else begin
                  st_nxt = ST_BAD_PSW;
                  if (fail_inc >= MAX_T) begin
                     wr_fail   = MAX_T[1:0];
                     wr_locked = 1'b1;
                  end else begin
                     wr_fail = fail_inc[1:0];
                  end
               end
            end
            OP_READ_BAL: begin
               if (same_card) rbal_nxt = rd_bal;
               else           st_nxt   = ST_NO_SESSION;
            end
            OP_UPDATE: begin
               if (same_card) begin
                  wr_en    = 1'b1;
                  wr_bal   = bal_q;
                  rbal_nxt = bal_q;
               end else begin
                  st_nxt = ST_NO_SESSION;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= S_IDLE;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_status  <= '0;
         resp_balance <= '0;
         session_open <= 1'b0;
         session_card <= '0;
         op_q         <= OP_VERIFY;
         card_q       <= '0;
         psw_q        <= '0;
         bal_q        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  op_q      <= op_e'(req_op);
                  card_q    <= req_card;
                  psw_q     <= req_password;
                  bal_q     <= req_balance;
                  req_ready <= 1'b0;
                  state     <= S_READ;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_READ: state <= S_EXEC;
            S_EXEC: begin
               resp_valid   <= 1'b1;
               resp_status  <= st_nxt;
               resp_balance <= rbal_nxt;
               state        <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
         // A card eject wins over anything EXEC decides this cycle.
         if (session_close) begin
            session_open <= 1'b0;
         end else if (state == S_EXEC) begin
            session_open <= sess_nxt;
            session_card <= sess_card_nxt;
         end
      end
   end
endmodule

// File: tb/tb_bank_account_server.sv
// Directed bench for bank_account_server: reset, auth, lock, session, backpressure.
module tb_bank_account_server;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [5:0]  req_card = '0;
   logic [15:0] req_password = '0;
   logic [19:0] req_balance = '0;
   logic        session_close = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [2:0]  resp_status;
   logic [19:0] resp_balance;
   logic        session_open;

   int nchk = 0;
   int nfail = 0;

   bank_account_server dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_card(req_card), .req_password(req_password),
      .req_balance(req_balance), .session_close(session_close),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
      .resp_balance(resp_balance), .session_open(session_open)
   );

   always #5 clk = ~clk;

   // Accept one request; return cycles from accept cycle T to first resp_valid (99 = timeout).
   task automatic issue(input logic [1:0] op, input logic [5:0] card, input logic [15:0] psw,
                        input logic [19:0] b, input bit close_exec, output int lat);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (req_ready !== 1'b1) begin lat = 99; return; end
      req_valid = 1'b1; req_op = op; req_card = card; req_password = psw; req_balance = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      if (close_exec) begin
         @(posedge clk); #1; n = 2;
         session_close = 1'b1;
         @(posedge clk); #1; n = 3;
         session_close = 1'b0;
      end
      while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      lat = (resp_valid === 1'b1) ? n : 99;
   endtask

   task automatic complete();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [5:0] card, input logic [15:0] psw,
                       input logic [19:0] b, output logic [2:0] st, output logic [19:0] bal, output int lat);
      issue(op, card, psw, b, 1'b0, lat);
      st = resp_status;
      bal = resp_balance;
      if (lat != 99) complete();
   endtask

   task automatic test_reset();
      logic [2:0] st; logic [19:0] bal; int lat;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nchk++;
      if ({req_ready, resp_valid, resp_status, resp_balance, session_open} !== 25'd0) begin
         nfail++; $display("FAIL reset_outputs got %h exp 0", {req_ready, resp_valid, resp_status, resp_balance, session_open});
      end
      rst = 1'b1;
      send(2'd0, 6'd5, 16'h0000, 20'd0, st, bal, lat);
      nchk++; if (lat != 3) begin nfail++; $display("FAIL t1_latency got %0d exp 3", lat); end
      nchk++; if (st !== 3'd3) begin nfail++; $display("FAIL t1_status got %0d exp 3", st); end
      nchk++; if (bal !== 20'd0) begin nfail++; $display("FAIL t1_balance got %0d exp 0", bal); end
   endtask

   task automatic test_provision_verify();
      logic [2:0] st; logic [19:0] bal; int lat;
      send(2'd3, 6'd5, 16'h1234, 20'd1000, st, bal, lat);
      nchk++; if (st !== 3'd0 || bal !== 20'd1000) begin nfail++; $display("FAIL t2_prov got %0d/%0d exp 0/1000", st, bal); end
      send(2'd0, 6'd5, 16'h1234, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd0 || bal !== 20'd1000) begin nfail++; $display("FAIL t2_verify got %0d/%0d exp 0/1000", st, bal); end
      nchk++; if (session_open !== 1'b1) begin nfail++; $display("FAIL t2_session got %b exp 1", session_open); end
   endtask

   task automatic test_lockout();
      logic [2:0] st; logic [19:0] bal; int lat;
      send(2'd3, 6'd9, 16'hBEEF, 20'd500, st, bal, lat);
      for (int i = 0; i < 3; i++) begin
         send(2'd0, 6'd9, 16'h0001, 20'd0, st, bal, lat);
         nchk++; if (st !== 3'd1) begin nfail++; $display("FAIL t3_bad%0d got %0d exp 1", i, st); end
      end
      send(2'd0, 6'd9, 16'hBEEF, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd2 || bal !== 20'd0) begin nfail++; $display("FAIL t3_locked got %0d/%0d exp 2/0", st, bal); end
      send(2'd3, 6'd9, 16'hBEEF, 20'd500, st, bal, lat);
      send(2'd0, 6'd9, 16'hBEEF, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd0 || bal !== 20'd500) begin nfail++; $display("FAIL t3_unlock got %0d/%0d exp 0/500", st, bal); end
   endtask

   task automatic test_session();
      logic [2:0] st; logic [19:0] bal; int lat;
      send(2'd3, 6'd6, 16'h6666, 20'd60, st, bal, lat);
      send(2'd0, 6'd5, 16'h1234, 20'd0, st, bal, lat);
      send(2'd2, 6'd5, 16'h0000, 20'd750, st, bal, lat);
      nchk++; if (st !== 3'd0 || bal !== 20'd750) begin nfail++; $display("FAIL t4_update got %0d/%0d exp 0/750", st, bal); end
      send(2'd1, 6'd6, 16'h0000, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd4 || bal !== 20'd0) begin nfail++; $display("FAIL t4_other_card got %0d/%0d exp 4/0", st, bal); end
      session_close = 1'b1; @(posedge clk); #1; session_close = 1'b0;
      nchk++; if (session_open !== 1'b0) begin nfail++; $display("FAIL t4_close got %b exp 0", session_open); end
      send(2'd2, 6'd5, 16'h0000, 20'd999, st, bal, lat);
      nchk++; if (st !== 3'd4) begin nfail++; $display("FAIL t4_nosess_update got %0d exp 4", st); end
      send(2'd0, 6'd5, 16'h1234, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd0 || bal !== 20'd750) begin nfail++; $display("FAIL t4_bal_kept got %0d/%0d exp 0/750", st, bal); end
   endtask

   task automatic test_backpressure();
      int lat; int bad;
      issue(2'd1, 6'd5, 16'h0000, 20'd0, 1'b0, lat);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (resp_valid !== 1'b1 || resp_status !== 3'd0 || resp_balance !== 20'd750 || req_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      nchk++; if (lat != 3 || bad != 0) begin nfail++; $display("FAIL t5_hold lat %0d unstable %0d exp 3/0", lat, bad); end
      complete();
      nchk++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin nfail++; $display("FAIL t5_release got rdy %b vld %b exp 1/0", req_ready, resp_valid); end
   endtask

   task automatic test_reset_midflight();
      logic [2:0] st; logic [19:0] bal; int lat; int seen;
      while (req_ready !== 1'b1) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_op = 2'd0; req_card = 6'd5; req_password = 16'h1234;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid !== 1'b0) seen++;
         @(posedge clk); #1;
      end
      nchk++; if (seen != 0 || session_open !== 1'b0) begin nfail++; $display("FAIL t6_drop resp seen %0d sess %b exp 0/0", seen, session_open); end
      send(2'd0, 6'd5, 16'h1234, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd3) begin nfail++; $display("FAIL t6_cleared5 got %0d exp 3", st); end
      send(2'd0, 6'd9, 16'hBEEF, 20'd0, st, bal, lat);
      nchk++; if (st !== 3'd3) begin nfail++; $display("FAIL t6_cleared9 got %0d exp 3", st); end
   endtask

   task automatic test_close_in_exec();
      logic [2:0] st; logic [19:0] bal; int lat;
      send(2'd3, 6'd5, 16'h1234, 20'd1000, st, bal, lat);
      send(2'd0, 6'd5, 16'h1234, 20'd0, st, bal, lat);
      issue(2'd2, 6'd5, 16'h0000, 20'd300, 1'b1, lat);
      nchk++; if (lat != 3 || resp_status !== 3'd0 || resp_balance !== 20'd300) begin
         nfail++; $display("FAIL t6_close_update lat %0d got %0d/%0d exp 3/0/300", lat, resp_status, resp_balance);
      end
      nchk++; if (session_open !== 1'b0) begin nfail++; $display("FAIL t6_close_sess got %b exp 0", session_open); end
      complete();
      issue(2'd0, 6'd5, 16'h1234, 20'd0, 1'b1, lat);
      nchk++; if (resp_status !== 3'd0 || resp_balance !== 20'd300) begin nfail++; $display("FAIL t6_committed got %0d/%0d exp 0/300", resp_status, resp_balance); end
      nchk++; if (session_open !== 1'b0) begin nfail++; $display("FAIL t6_close_over_verify got %b exp 0", session_open); end
      complete();
   endtask

   initial begin
      test_reset();
      test_provision_verify();
      test_lockout();
      test_session();
      test_backpressure();
      test_reset_midflight();
      test_close_in_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end
endmodule
